// File: rtl/route_pkg.sv
// Shared definitions for the two-port router: ingress word layout and the
// scheduler state encoding.
package route_pkg;
  localparam int WORD_W      = 10;
  localparam int PRIO_BIT    = 9;
  localparam int DEST_BIT    = 8;
  localparam int PAYLOAD_MSB = 7;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [PAYLOAD_MSB:0] payload_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/route_sched_if.sv
// Ingress/egress FIFO-side signals of the scheduler, grouped as one bundle.
interface route_sched_if;
  import route_pkg::*;

  // Handshake: an ingress word is valid while empty_i=0 (first-word
  // fall-through); pop_i is the same-cycle ack. push_d is a one-cycle strobe
  // with no ready; pause_d is only looked at when a grant is made, so the
  // egress FIFO must still absorb the one word already in flight.
  word_t    head0, head1;
  logic     empty0, empty1;
  logic     pause0, pause1;
  logic     pop0, pop1;
  logic     push0, push1;
  payload_t data_out0, data_out1;

  modport master (
    input  head0, head1, empty0, empty1, pause0, pause1,
    output pop0, pop1, push0, push1, data_out0, data_out1
  );

  modport slave (
    output head0, head1, empty0, empty1, pause0, pause1,
    input  pop0, pop1, push0, push1, data_out0, data_out1
  );
endinterface

// File: rtl/route_sched_starve_wdog.sv
// Per-ingress starvation watchdog: counts consecutive RUN cycles in which a
// pending ingress was not granted, saturating at STARVE_MAX.
module starve_wdog #(
  parameter int STARVE_MAX = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic pending,
  input  logic granted,
  output logic starved
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (granted || !pending) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != CW'(STARVE_MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign starved = (r_cnt == CW'(STARVE_MAX));
endmodule

// File: rtl/route_sched.sv
// Ingress scheduler: picks at most one ingress head per cycle (priority, then
// round-robin), pops it, and pushes its payload to the addressed egress.
module route_sched
  import route_pkg::*;
#(
  parameter int STARVE_MAX = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  route_sched_if.master     bus,
  output logic [1:0]        grant,
  output logic              idle,
  output logic              err,
  output logic [1:0]        err_src,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output state_t            o_dbg_state
);
  state_t     r_state, w_next;
  logic       w_run, w_elig0, w_elig1, w_any, w_sel1, w_gnt0, w_gnt1;
  logic       w_dest;
  payload_t   w_payload;
  logic       w_starved0, w_starved1;
  logic       r_rr;
  logic       r_push0, r_push1;
  payload_t   r_data0, r_data1;
  logic [1:0] r_grant, r_err_src;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable)  w_next = RUN;
      RUN:     if (!enable) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Pause is looked up through each head's own destination bit.
  always_comb begin
    w_run   = (r_state == RUN);
    w_elig0 = w_run && enable && !bus.empty0 &&
              !(bus.head0[DEST_BIT] ? bus.pause1 : bus.pause0);
    w_elig1 = w_run && enable && !bus.empty1 &&
              !(bus.head1[DEST_BIT] ? bus.pause1 : bus.pause0);
    w_any   = w_elig0 || w_elig1;
    if (w_elig0 && w_elig1) begin
      if (bus.head0[PRIO_BIT] != bus.head1[PRIO_BIT]) w_sel1 = bus.head1[PRIO_BIT];
      else                                            w_sel1 = r_rr;
    end else begin
      w_sel1 = w_elig1;
    end
    w_gnt0    = w_any && !w_sel1;
    w_gnt1    = w_any && w_sel1;
    w_dest    = w_sel1 ? bus.head1[DEST_BIT] : bus.head0[DEST_BIT];
    w_payload = w_sel1 ? bus.head1[PAYLOAD_MSB:0] : bus.head0[PAYLOAD_MSB:0];
  end

  starve_wdog #(.STARVE_MAX(STARVE_MAX)) u_wdog0 (
    .clk(clk), .reset(reset), .run(w_run), .pending(!bus.empty0),
    .granted(w_gnt0), .starved(w_starved0)
  );

  starve_wdog #(.STARVE_MAX(STARVE_MAX)) u_wdog1 (
    .clk(clk), .reset(reset), .run(w_run), .pending(!bus.empty1),
    .granted(w_gnt1), .starved(w_starved1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr      <= 1'b0;
      r_push0   <= 1'b0;
      r_push1   <= 1'b0;
      r_data0   <= '0;
      r_data1   <= '0;
      r_grant   <= 2'b00;
      r_err_src <= 2'b00;
      r_cnt0    <= '0;
      r_cnt1    <= '0;
    end else begin
      r_push0 <= w_any && !w_dest;
      r_push1 <= w_any && w_dest;
      if (w_any) begin
        r_rr    <= !w_sel1;
        r_grant <= {w_sel1, !w_sel1};
        if (w_dest) r_data1 <= w_payload;
        else        r_data0 <= w_payload;
      end
      r_cnt0    <= r_cnt0 + CNT_W'(r_push0);
      r_cnt1    <= r_cnt1 + CNT_W'(r_push1);
      r_err_src <= r_err_src | {w_starved1, w_starved0};
    end
  end

  assign bus.pop0      = w_gnt0;
  assign bus.pop1      = w_gnt1;
  assign bus.push0     = r_push0;
  assign bus.push1     = r_push1;
  assign bus.data_out0 = r_data0;
  assign bus.data_out1 = r_data1;
  assign grant         = r_grant;
  assign idle          = (r_state == IDLE) && !r_push0 && !r_push1;
  assign err           = |r_err_src;
  assign err_src       = r_err_src;
  assign cnt0          = r_cnt0;
  assign cnt1          = r_cnt1;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_route_sched.sv
// Bench for route_sched: per-cycle vector tables plus hand-written corner
// sequences; pushes are checked against an expected queue.
module tb_route_sched;
  import route_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;

  typedef struct {
    logic       rst;
    logic       en;
    logic [9:0] h0;
    logic [9:0] h1;
    logic       e0;
    logic       e1;
    logic       p0;
    logic       p1;
    logic       cp;
    logic [1:0] pop;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic enable;
  always #5 clk = ~clk;

  logic [1:0]       grant, err_src;
  logic             idle, err;
  logic [CNT_W-1:0] cnt0, cnt1;
  state_t           dbg_state;

  route_sched_if rif();

  route_sched #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(rif),
    .grant(grant), .idle(idle), .err(err), .err_src(err_src),
    .cnt0(cnt0), .cnt1(cnt1), .o_dbg_state(dbg_state)
  );

  int         n_vec = 0;
  int         n_err = 0;
  string      cur   = "init";
  logic [9:0] exp_q[$];
  vec_t       vecs[$];

  function automatic vec_t mk(input logic rst, input logic en,
                              input logic [9:0] h0, input logic [9:0] h1,
                              input logic e0, input logic e1,
                              input logic p0, input logic p1,
                              input logic cp, input logic [1:0] pop);
    vec_t v;
    v.rst = rst; v.en = en; v.h0 = h0; v.h1 = h1;
    v.e0 = e0; v.e1 = e1; v.p0 = p0; v.p1 = p1;
    v.cp = cp; v.pop = pop;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur, nm, act, exp);
    end
  endtask

  task automatic sb_check();
    logic [9:0] act;
    logic [9:0] exp;
    act = {rif.push1, rif.push0, rif.push1 ? rif.data_out1 : rif.data_out0};
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("push", 32'(act), 32'(exp));
    end else begin
      chk("nopush", 32'({rif.push1, rif.push0}), 32'd0);
    end
  endtask

  // driver
  task automatic apply(input vec_t v);
    @(negedge clk);
    reset      = v.rst;
    enable     = v.en;
    rif.head0  = v.h0;
    rif.head1  = v.h1;
    rif.empty0 = v.e0;
    rif.empty1 = v.e1;
    rif.pause0 = v.p0;
    rif.pause1 = v.p1;
    #1;
    sb_check();
    if (v.cp) begin
      chk("pop", 32'({rif.pop1, rif.pop0}), 32'(v.pop));
      if (v.pop[0]) exp_q.push_back({v.h0[8], !v.h0[8], v.h0[7:0]});
      if (v.pop[1]) exp_q.push_back({v.h1[8], !v.h1[8], v.h1[7:0]});
    end
    if (v.rst) exp_q.delete();
  endtask

  task automatic run_table(input string nm);
    cur = nm;
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  task automatic check_reset_vals();
    chk("rv.push",  32'({rif.push1, rif.push0}), 32'd0);
    chk("rv.data0", 32'(rif.data_out0), 32'd0);
    chk("rv.data1", 32'(rif.data_out1), 32'd0);
    chk("rv.grant", 32'(grant), 32'd0);
    chk("rv.idle",  32'(idle), 32'd1);
    chk("rv.err",   32'(err), 32'd0);
    chk("rv.esrc",  32'(err_src), 32'd0);
    chk("rv.cnt0",  32'(cnt0), 32'd0);
    chk("rv.cnt1",  32'(cnt1), 32'd0);
    chk("rv.state", 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    cur = "reset";
    repeat (2) apply(mk(1, 0, 10'h000, 10'h000, 1, 1, 0, 0, 1, 2'b00));
    check_reset_vals();
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    rif.head0  = '0;
    rif.head1  = '0;
    rif.empty0 = 1'b1;
    rif.empty1 = 1'b1;
    rif.pause0 = 1'b0;
    rif.pause1 = 1'b0;
    repeat (2) @(posedge clk);

    // single stream from ingress0: dest1 then dest0
    do_reset();
    vecs.push_back(mk(0, 1, 10'h105, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    vecs.push_back(mk(0, 1, 10'h105, 10'h000, 0, 1, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 10'h006, 10'h000, 0, 1, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 10'h006, 10'h000, 1, 1, 0, 0, 1, 2'b00));
    vecs.push_back(mk(0, 1, 10'h006, 10'h000, 1, 1, 0, 0, 1, 2'b00));
    run_table("single");
    chk("cnt0",  32'(cnt0), 32'd1);
    chk("cnt1",  32'(cnt1), 32'd1);
    chk("grant", 32'(grant), 32'd1);
    chk("data1", 32'(rif.data_out1), 32'h05);
    chk("data0", 32'(rif.data_out0), 32'h06);

    // round-robin, equal priority, both to egress0
    do_reset();
    vecs.push_back(mk(0, 1, 10'h0A1, 10'h0B2, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(0, 1, 10'h0A1, 10'h0B2, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 10'h0A3, 10'h0B2, 0, 0, 0, 0, 1, 2'b10));
    vecs.push_back(mk(0, 1, 10'h0A3, 10'h0B4, 0, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 10'h0A5, 10'h0B4, 0, 0, 0, 0, 1, 2'b10));
    vecs.push_back(mk(0, 1, 10'h0A5, 10'h0B4, 1, 1, 0, 0, 1, 2'b00));
    vecs.push_back(mk(0, 1, 10'h0A5, 10'h0B4, 1, 1, 0, 0, 1, 2'b00));
    run_table("rr");
    chk("cnt0",  32'(cnt0), 32'd4);
    chk("cnt1",  32'(cnt1), 32'd0);
    chk("grant", 32'(grant), 32'd2);

    // priority beats round-robin pointer
    do_reset();
    vecs.push_back(mk(0, 1, 10'h011, 10'h222, 0, 0, 0, 0, 1, 2'b00));
    vecs.push_back(mk(0, 1, 10'h011, 10'h222, 0, 0, 0, 0, 1, 2'b10));
    vecs.push_back(mk(0, 1, 10'h011, 10'h222, 0, 1, 0, 0, 1, 2'b01));
    vecs.push_back(mk(0, 1, 10'h011, 10'h222, 1, 1, 0, 0, 1, 2'b00));
    run_table("prio");
    chk("grant", 32'(grant), 32'd1);

    // pause blocks ingress0 until its watchdog trips
    do_reset();
    cur = "pause";
    apply(mk(0, 1, 10'h1C0, 10'h033, 0, 0, 0, 1, 1, 2'b00));
    apply(mk(0, 1, 10'h1C0, 10'h033, 0, 0, 0, 1, 1, 2'b10));
    for (int k = 0; k < 4; k++) apply(mk(0, 1, 10'h1C0, 10'h033, 0, 1, 0, 1, 1, 2'b00));
    chk("err_early", 32'(err), 32'd0);
    apply(mk(0, 1, 10'h1C0, 10'h033, 0, 1, 0, 1, 1, 2'b00));
    chk("err",  32'(err), 32'd1);
    chk("esrc", 32'(err_src), 32'd1);
    apply(mk(0, 1, 10'h1C0, 10'h033, 0, 1, 0, 0, 1, 2'b01));
    chk("err_hold", 32'(err), 32'd1);
    apply(mk(0, 1, 10'h1C0, 10'h033, 1, 1, 0, 0, 1, 2'b00));
    chk("esrc_hold", 32'(err_src), 32'd1);
    chk("cnt0", 32'(cnt0), 32'd1);

    // enable drop right after a grant
    do_reset();
    cur = "en_drop";
    apply(mk(0, 1, 10'h044, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    apply(mk(0, 1, 10'h044, 10'h000, 0, 1, 0, 0, 1, 2'b01));
    apply(mk(0, 0, 10'h055, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    chk("idle_t1", 32'(idle), 32'd0);
    apply(mk(0, 0, 10'h055, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    chk("idle_t2", 32'(idle), 32'd1);
    chk("state",   32'(dbg_state), 32'(IDLE));
    chk("cnt0",    32'(cnt0), 32'd1);

    // reset lands on the edge that would register the push
    do_reset();
    cur = "rst_mid";
    apply(mk(0, 1, 10'h066, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    apply(mk(1, 1, 10'h066, 10'h000, 0, 1, 0, 0, 0, 2'b00));
    apply(mk(0, 0, 10'h066, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    check_reset_vals();

    // 17 pushes to egress0 wrap a 4-bit counter
    do_reset();
    cur = "wrap";
    apply(mk(0, 1, 10'h000, 10'h000, 0, 1, 0, 0, 1, 2'b00));
    for (int k = 0; k < 17; k++) begin
      logic [9:0] h;
      h = {1'($urandom_range(0, 1)), 1'b0, 8'($urandom_range(0, 255))};
      apply(mk(0, 1, h, 10'h000, 0, 1, 0, 0, 1, 2'b01));
    end
    apply(mk(0, 1, 10'h000, 10'h000, 1, 1, 0, 0, 1, 2'b00));
    apply(mk(0, 1, 10'h000, 10'h000, 1, 1, 0, 0, 1, 2'b00));
    chk("cnt0", 32'(cnt0), 32'd1);
    chk("cnt1", 32'(cnt1), 32'd0);
    chk("err",  32'(err), 32'd0);

    // final report
    cur = "end";
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/route_sched.md
# route_sched

Ingress scheduler for the two-port router. It sits between the two ingress FIFOs and the route datapath. Each cycle it picks at most one ingress head word whose destination egress FIFO is not paused, pops it, and presents the 8-bit payload plus a push strobe to the selected egress one cycle later. It also runs per-ingress starvation watchdogs and per-egress transfer counters.

## Interface
- STARVE_MAX, default 64: cycles a non-empty ingress may go ungranted before `err` sets.
- CNT_W, default 16: width of the egress transfer counters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- enable  in  1  permits new grants
- head0, head1  in  10  ingress FIFO head word (first-word fall-through). [9]=prio, [8]=dest (0→egress0, 1→egress1), [7:0]=payload.
- empty0, empty1  in  1  ingress FIFO empty
- pause0, pause1  in  1  egress FIFO pause (almost-full)
- pop0, pop1  out  1  ingress pop, combinational, same cycle as grant
- push0, push1  out  1  egress push, registered
- data_out0, data_out1  out  8  egress payload, registered
- grant  out  2  one-hot of last granted ingress, registered
- idle  out  1  state IDLE and no push in flight
- err  out  1  sticky starvation error
- err_src  out  2  sticky; bit i set if ingress i starved
- cnt0, cnt1  out  CNT_W  pushes issued to egress 0/1, wrap-around

## Operation
- FSM states:
  - IDLE: enable=1 → RUN.
  - RUN: enable=0 → IDLE.
  - Reset → IDLE.
- Eligibility: ingress i is eligible iff state==RUN, enable=1, empty_i=0, and pause[head_i[8]]=0.
- Selection, at most one grant per cycle:
  - If one ingress is eligible, grant it.
  - If both are eligible and exactly one has prio=1, grant that one.
  - Otherwise grant the ingress pointed to by `rr`.
- `rr` updates on every grant to point at the non-granted ingress. Reset value of `rr` is 0.
- Both heads targeting the same or different egresses: still one grant only. The loser stays pending.
- Grant of ingress i in cycle t:
  - pop_i=1 in cycle t.
  - In t+1: push[d]=1, data_out[d]=head_i[7:0] captured at t, where d=head_i[8] captured at t. The other push is 0.
  - `grant` updates to the one-hot of i.
- data_out holds its last value when push=0.
- Pause is sampled only at grant time. Each egress FIFO must accept one in-flight word after asserting pause.
- Watchdog i:
  - Clears when ingress i is granted or empty_i=1.
  - Otherwise increments each cycle in RUN.
  - Holds in IDLE.
  - Reaching STARVE_MAX sets err and err_src[i]. The counter then saturates.
- err and err_src clear only on reset. Scheduling continues after err.
- cnt_d increments on each push_d, modulo 2^CNT_W.
- Reset mid-operation: all state clears on the reset edge. A push scheduled for the next cycle is dropped.
- Reset values: pop 0 (state IDLE), push 0, data_out 0, grant 2'b00, idle 1, err 0, err_src 0, cnt 0, rr 0, watchdogs 0.

## Timing
- Grant latency: first grant possible in the cycle after enable is sampled high in IDLE.
- Pop to push: 1 cycle.
- Throughput: 1 word/cycle aggregate.
- Deasserting enable blocks grants in that same cycle. A push from the previous cycle's grant still completes.
- idle rises the cycle after the last push once state is IDLE.
- Watchdog: err is asserted in the cycle after the counter reaches STARVE_MAX, i.e. STARVE_MAX+1 consecutive cycles blocked.

## Structure
- Shared package route_pkg:
  - field constants PRIO_BIT=9, DEST_BIT=8, PAYLOAD_MSB=7
  - state encoding IDLE/RUN
  - word width 10
- Sub-module starve_wdog, instanced twice. Inputs: clk, reset, run, pending, granted. Parameter STARVE_MAX. Output: starved.
- Arbitration, pipeline register and counters live in the top module.

## Test plan
- Single stream: enable=1, ingress0 holds heads 0x105, 0x006, ingress1 empty, no pause → pop0 in two consecutive cycles. push1 with data 0x05, then push0 with data 0x06, each one cycle after its pop. cnt1=1, cnt0=1.
- Round-robin: both ingresses always non-empty, prio=0, dest=0 → grants alternate 0,1,0,1 starting with ingress 0. One push0 per cycle.
- Priority: head0=0x011 (prio 0), head1=0x222 (prio 1, dest 0), rr=0 → ingress1 is granted first.
- Pause: pause1=1 with head0 dest=1 and head1 dest=0 → only ingress1 is granted. Once ingress1 is empty, pop0 stays 0 while pause1=1. With STARVE_MAX=4, err=1 and err_src=2'b01 after 5 blocked cycles. err stays set after pause1 drops.
- Enable/reset mid-flight: grant in cycle t, enable=0 at t+1 → push still occurs at t+1, no further pops, idle=1 at t+2. Repeating with reset at t+1 instead → push=0 and all outputs at reset values.
- Counter wrap: CNT_W=4, 17 pushes to egress0 → cnt0=1.
